// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage between the PC and the IF/ID register.
// Issues one request per PC value, holds the PC while the memory is slow,
// discards responses made stale by a flush and parks a returned word in a
// hold buffer while decode is stalled.
// Optional feature: define FETCH_PERF_CNT_EN to add the 16-bit saturating
// bubble counter output O_bubble_cnt.
module inst_fetch #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] I_inst_addr,
    output logic              O_stall_pc,
    input  logic              I_flush,
    input  logic              I_stall_id,
    output logic              O_imem_req,
    output logic [ADDR_W-1:0] O_imem_addr,
    input  logic              I_imem_ack,
    input  logic [INST_W-1:0] I_imem_rdata,
    output logic [INST_W-1:0] O_inst,
    output logic [ADDR_W-1:0] O_inst_pc,
    output logic              O_inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       O_bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;

    // IF/ID load request produced by the FSM for this cycle
    logic              load;
    logic [INST_W-1:0] load_inst;
    logic [ADDR_W-1:0] load_pc;

    // Next-state, memory request, PC stall and hold-buffer capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        O_imem_req  = 1'b0;
        O_imem_addr = addr_q;
        O_stall_pc  = 1'b1;
        load        = 1'b0;
        load_inst   = hold_inst_q;
        load_pc     = hold_pc_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                O_imem_req  = 1'b1;
                O_imem_addr = I_inst_addr;
                addr_d      = I_inst_addr;
                if (I_flush) begin
                    // PC takes the target; an unanswered request must drain
                    O_stall_pc = 1'b0;
                    if (!I_imem_ack) begin
                        state_d = DRAIN;
                    end
                end else if (I_imem_ack) begin
                    if (I_stall_id) begin
                        hold_inst_d = I_imem_rdata;
                        hold_pc_d   = I_inst_addr;
                        state_d     = HOLD;
                    end else begin
                        load       = 1'b1;
                        load_inst  = I_imem_rdata;
                        load_pc    = I_inst_addr;
                        O_stall_pc = 1'b0;
                    end
                end
            end
            DRAIN: begin
                // Keep the stale request alive at its original address
                O_imem_req = 1'b1;
                O_stall_pc = !I_flush;
                if (I_imem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (I_flush) begin
                    O_stall_pc = 1'b0;
                    state_d    = REQ;
                end else if (!I_stall_id) begin
                    load       = 1'b1;
                    O_stall_pc = 1'b0;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (I_flush) begin
            hold_inst_d = '0;
            hold_pc_d   = '0;
        end
    end

    // IF/ID register update: flush beats stall, stall beats load, else bubble
    always_comb begin
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        if (I_flush) begin
            inst_valid_d = 1'b0;
        end else if (I_stall_id) begin
            inst_valid_d = inst_valid_q;
        end else if (load) begin
            inst_d       = load_inst;
            inst_pc_d    = load_pc;
            inst_valid_d = 1'b1;
        end else begin
            inst_valid_d = 1'b0;
        end
    end

    // State, address and IF/ID registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign O_inst       = inst_q;
    assign O_inst_pc    = inst_pc_q;
    assign O_inst_valid = inst_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic        bubble;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating count of bubble cycles inserted into IF/ID
    always_comb begin
        bubble       = !I_flush && !I_stall_id && !load;
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign O_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL use parameter INST_W, default 32, as the instruction word width.
REQ-002 The block SHALL use parameter ADDR_W, default 8, as the instruction address width, matching the PC width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; every flop uses its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port I_inst_addr, input, ADDR_W bits: the current PC value.
REQ-006 The block SHALL have port O_stall_pc, output, 1 bit: drives the PC STALL input; 1 = hold the PC.
REQ-007 The block SHALL have port I_flush, input, 1 bit: branch or jump taken; the PC loads the target on the same edge.
REQ-008 The block SHALL have port I_stall_id, input, 1 bit: the decode stage holds the IF/ID register.
REQ-009 The block SHALL have ports O_imem_req (output, 1 bit) and O_imem_addr (output, ADDR_W bits): the instruction-memory request and its address.
REQ-010 The block SHALL have ports I_imem_ack (input, 1 bit) and I_imem_rdata (input, INST_W bits): response valid and read data.
REQ-011 The block SHALL have ports O_inst (output, INST_W bits), O_inst_pc (output, ADDR_W bits) and O_inst_valid (output, 1 bit): the IF/ID register contents.

Function
REQ-012 The block SHALL implement the FSM states IDLE, REQ, DRAIN and HOLD.
REQ-013 IDLE SHALL move to REQ on the next cycle unconditionally; in IDLE: req=0, stall_pc=1.
REQ-014 In REQ, O_imem_req SHALL be 1 and O_imem_addr SHALL equal I_inst_addr; the address register addr_q SHALL load I_inst_addr every REQ cycle.
REQ-015 In REQ with I_imem_ack=1, I_flush=0 and I_stall_id=0, the block SHALL do all of the following:
- load O_inst=I_imem_rdata, O_inst_pc=I_inst_addr and O_inst_valid=1;
- set stall_pc=0 for that cycle, so the PC advances;
- stay in REQ.
REQ-016 A zero-wait memory, with ack in the same cycle as req, SHALL sustain one instruction per cycle.
REQ-017 In REQ with ack=1, I_stall_id=1 and I_flush=0, the block SHALL capture rdata and address into the hold buffer and go to HOLD, with stall_pc=1.
REQ-018 In REQ with ack=0, the block SHALL keep stall_pc=1 and keep req asserted.
REQ-019 In REQ with I_flush=1 and ack=0, the block SHALL go to DRAIN; the request stays outstanding at the pre-flush address.
REQ-020 In REQ with I_flush=1 and ack=1, the block SHALL discard the data and stay in REQ.
REQ-021 In DRAIN, the block SHALL keep req=1 with O_imem_addr=addr_q and stall_pc=1.
REQ-022 In DRAIN, an ack SHALL be discarded and the FSM SHALL go to REQ; a further flush SHALL keep the FSM in DRAIN.
REQ-023 In HOLD, req SHALL be 0 and stall_pc SHALL be 1.
REQ-024 In HOLD, when I_stall_id falls, the block SHALL load the hold buffer into IF/ID, set stall_pc=0 and go to REQ.
REQ-025 I_flush SHALL force stall_pc=0 in every state except IDLE, so the PC takes the target.
REQ-026 I_flush SHALL clear O_inst_valid and the hold buffer, and SHALL take priority over I_stall_id.
REQ-027 When I_stall_id=1 and there is no flush, the block SHALL hold O_inst, O_inst_pc and O_inst_valid unchanged.
REQ-028 When I_stall_id=0 and no instruction is loaded that cycle, the block SHALL set O_inst_valid=0 (bubble).
REQ-029 O_imem_req SHALL never deassert before ack while a request is outstanding.

Reset
REQ-030 rst_n=0 SHALL asynchronously force the following:
- state=IDLE;
- O_inst=0, O_inst_pc=0, O_inst_valid=0;
- O_imem_req=0, addr_q=0, hold buffer cleared;
- O_stall_pc=1.
REQ-031 An assertion of rst_n mid-request SHALL abandon the outstanding request without waiting for ack.
REQ-032 The first request after rst_n deasserts SHALL be issued on the second rising edge.

Configuration
REQ-033 With macro FETCH_PERF_CNT_EN defined, the block SHALL add output O_bubble_cnt, 16 bits, reset 0.
- O_bubble_cnt SHALL increment in each cycle where REQ-028 inserts a bubble.
- O_bubble_cnt SHALL saturate at 16'hFFFF.
REQ-034 Without FETCH_PERF_CNT_EN, the port and the counter SHALL be absent, and the rest of the behaviour SHALL be unchanged.

Verification
REQ-035 Zero-wait memory, PC 0..3 with rdata=addr+32'h100 -> O_inst shows 0x100, 0x101, 0x102, 0x103 on consecutive cycles, with valid=1 throughout.
REQ-036 Ack delayed 3 cycles at PC=5 -> stall_pc=1 for 3 cycles, 3 bubbles, then O_inst_pc=5.
REQ-037 Flush at PC=7 with ack 2 cycles late, PC target 0x40 -> the late data is discarded, the next request address is 0x40, and valid=0 until 0x40 is returned.
REQ-038 Ack at PC=9 while I_stall_id=1 for 4 cycles -> HOLD, no new req; after the stall releases, O_inst_pc=9 and the PC advances to 10.
REQ-039 rst_n pulsed low mid-DRAIN -> all outputs are 0 and stall_pc=1 immediately, and the first req is issued on the second edge after release.
REQ-040 FETCH_PERF_CNT_EN defined -> O_bubble_cnt=3 after the REQ-036 scenario; O_bubble_cnt holds at 0xFFFF when forced to saturate.
